// File: rtl/mips_debug_pkg.sv
// Shared definitions for the debug dump path: dumper state encoding, word/byte
// geometry and the debug-UART byte handshake constants (also used by the
// register-file dumper).
package mips_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

  // Debug UART moves one byte per valid/ready handshake.
  localparam int UART_BYTE_WIDTH  = 8;

  localparam int DEBUG_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD   = DEBUG_DATA_WIDTH / UART_BYTE_WIDTH;

  // Byte count for an arbitrary word width (must be a multiple of 8).
  function automatic int bytes_per_word(input int data_width);
    return data_width / UART_BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/mem_debug_dump_word_byte_serializer.sv
// Splits one captured word into bytes, LSB first, over a valid/ready byte
// handshake. i_load captures a word and starts presenting byte 0;
// o_last_accepted flags the cycle in which the final byte is taken.
module word_byte_serializer
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH = DEBUG_DATA_WIDTH,
  parameter int BYTES      = BYTES_PER_WORD
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic [DATA_WIDTH-1:0]      i_word,
  output logic [UART_BYTE_WIDTH-1:0] o_tx_data,
  output logic                       o_tx_valid,
  input  logic                       i_tx_ready,
  output logic                       o_last_accepted
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic                  valid_q, valid_d;
  logic                  fire;
  logic                  is_last;

  // Next-state: load a fresh word, or advance one byte per accepted handshake.
  always_comb begin
    fire       = valid_q & i_tx_ready;
    is_last    = (byte_cnt_q == CNT_W'(BYTES - 1));
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    valid_d    = valid_q;
    if (i_load) begin
      shift_d    = i_word;
      byte_cnt_d = '0;
      valid_d    = 1'b1;
    end else if (fire) begin
      if (is_last) begin
        valid_d = 1'b0;
      end else begin
        shift_d    = shift_q >> UART_BYTE_WIDTH;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  // State registers; valid is only dropped after the last byte is taken.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign o_tx_data       = shift_q[UART_BYTE_WIDTH-1:0];
  assign o_tx_valid      = valid_q;
  assign o_last_accepted = fire & is_last;

endmodule

// File: rtl/mem_debug_dump.sv
// Dumps every data-memory word to the debug UART. The block owns the memory's
// debug step line, so its word index and the memory's debug counter advance
// together; each dump issues exactly MEM_DEPTH steps, returning both to 0.
module mem_debug_dump
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_mem_debug,
  output logic                  o_debug_step,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IDX_WIDTH-1:0]  o_word_index
);

  localparam int WORD_BYTES = bytes_per_word(DATA_WIDTH);

  dump_state_e          state_q, state_d;
  logic [IDX_WIDTH-1:0] word_index_q, word_index_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 step_q, step_d;
  logic                 load;
  logic                 last_accepted;

  // Capture happens on the edge that leaves LOAD; by then the memory has
  // already advanced on the falling edge inside the preceding STEP cycle.
  assign load = (state_q == ST_LOAD);

  word_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTES      (WORD_BYTES)
  ) u_serializer (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_load          (load),
    .i_word          (i_mem_debug),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_last_accepted (last_accepted)
  );

  // Next-state and next-output decode; outputs are registered from the
  // next state so they always match the state register.
  always_comb begin
    state_d      = state_q;
    word_index_d = word_index_q;
    unique case (state_q)
      ST_IDLE: if (i_start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (last_accepted) state_d = ST_STEP;
      ST_STEP: begin
        if (word_index_q == IDX_WIDTH'(MEM_DEPTH - 1)) begin
          word_index_d = '0;
          state_d      = ST_DONE;
        end else begin
          word_index_d = word_index_q + 1'b1;
          state_d      = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    step_d = (state_d == ST_STEP);
  end

  // FSM state, word index and registered control outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      word_index_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_index_q <= word_index_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_q       <= step_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_debug_step = step_q;
  assign o_word_index = word_index_q;

endmodule

// File: tb/tb_mem_debug_dump.sv
// Bench for mem_debug_dump: a debug-counter memory model driven by the DUT's
// step line, a byte monitor feeding a received-byte queue, and per-scenario
// tasks that queue expected bytes when a dump is started and compare them.
module tb_mem_debug_dump;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int IW    = 5;
  localparam int BPW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [DW-1:0] mem_word;
  logic          step;
  logic [7:0]    txd;
  logic          txv;
  logic          busy;
  logic          done;
  logic [IW-1:0] widx;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] mem_cnt;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int step_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  mem_debug_dump #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .IDX_WIDTH(IW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_mem_debug  (mem_word),
    .o_debug_step (step),
    .o_tx_data    (txd),
    .o_tx_valid   (txv),
    .i_tx_ready   (ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_word_index (widx)
  );

  always #5 clk = ~clk;

  // Memory debug counter: reset by the shared reset, advanced by a step seen
  // in the middle of the cycle (falling edge).
  always @(negedge clk) begin
    #2;
    if (rst) mem_cnt <= '0;
    else if (step) mem_cnt <= mem_cnt + 1'b1;
  end
  assign mem_word = mem[mem_cnt];

  // Monitor: record bytes that will be accepted on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (txv && ready) got_q.push_back(txd);
      if (step) step_cnt++;
      if (step && txv) overlap_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_dump();
    for (int k = 0; k < DEPTH; k++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(mem[k][8*b +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      cycle();
      edges++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    cycle();
    n_checks++;
    if ({busy, txv, done, step, widx, txd} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {busy, txv, done, step, widx, txd});
    else n_pass++;
    rst = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if ({busy, txv, step} !== 3'b000)
      $display("FAIL idle_no_start: got %b required 000", {busy, txv, step});
    else n_pass++;
  endtask

  task automatic test_full_dump();
    int s0, e, mism;
    bit ok;
    logic [7:0] head [8];
    head = '{8'h00, 8'hC0, 8'hB0, 8'hA0, 8'h01, 8'hC1, 8'hB0, 8'hA0};
    exp_q.delete(); got_q.delete();
    s0 = step_cnt;
    push_dump();
    pulse_start();
    n_checks++;
    if ({busy, txv} !== 2'b10) $display("FAIL load_state: got %b required 10", {busy, txv});
    else n_pass++;
    cycle();
    n_checks++;
    if ({txv, txd} !== {1'b1, 8'h00})
      $display("FAIL first_valid: got %b/%h required 1/00", txv, txd);
    else n_pass++;
    wait_done(1'b0, e, ok);
    n_checks++;
    if (!ok || (e + 1) != 192) $display("FAIL done_latency: got %0d ok=%0d required 192", e + 1, ok);
    else n_pass++;
    cycle();
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL done_pulse_width: got %b required 00", {done, busy});
    else n_pass++;
    repeat (3) cycle();
    n_checks++;
    if (step_cnt - s0 != 32) $display("FAIL full_steps: got %0d required 32", step_cnt - s0);
    else n_pass++;
    mism = 0;
    for (int i = 0; i < 8; i++) if (got_q.size() > i && got_q[i] !== head[i]) mism++;
    n_checks++;
    if (got_q.size() < 8 || mism != 0) $display("FAIL first_bytes: got %0d mismatches required 0", mism);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 128 || {got_q[8], got_q[9], got_q[10], got_q[11]} !== 32'h63000000 ||
        {got_q[124], got_q[125], got_q[126], got_q[127]} !== 32'h64000000)
      $display("FAIL word2_word31: got size %0d required 128 with 63 00 00 00 / 64 00 00 00", got_q.size());
    else n_pass++;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (mism != 0 || got_q.size() != exp_q.size())
      $display("FAIL full_stream: got %0d bytes %0d mismatches required %0d bytes 0", got_q.size(), mism, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int s0, e, mism;
    bit ok, found;
    exp_q.delete(); got_q.delete();
    s0 = step_cnt;
    push_dump();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (widx == 5'd3 && txv && txd == 8'h03) begin found = 1'b1; break; end
      cycle();
    end
    n_checks++;
    if (!found) $display("FAIL bp_reach_word3: got none required byte 03 of word 3");
    else n_pass++;
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({txv, txd} !== {1'b1, 8'hC3})
        $display("FAIL bp_hold_%0d: got %b/%h required 1/c3", i, txv, txd);
      else n_pass++;
      cycle();
    end
    n_checks++;
    if ({txv, txd} !== {1'b1, 8'hC3}) $display("FAIL bp_release: got %b/%h required 1/c3", txv, txd);
    else n_pass++;
    ready = 1'b1;
    wait_done(1'b0, e, ok);
    repeat (3) cycle();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (!ok || mism != 0 || got_q.size() != exp_q.size() || step_cnt - s0 != 32)
      $display("FAIL bp_stream: got %0d bytes %0d mismatches %0d steps ok=%0d required 128/0/32/1",
               got_q.size(), mism, step_cnt - s0, ok);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int s0, d0, e, mism;
    bit ok;
    exp_q.delete(); got_q.delete();
    s0 = step_cnt; d0 = done_cnt;
    push_dump();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (widx == 5'd7) break;
      cycle();
    end
    pulse_start();
    wait_done(1'b0, e, ok);
    repeat (10) cycle();
    n_checks++;
    if (!ok || done_cnt - d0 != 1 || step_cnt - s0 != 32)
      $display("FAIL ignore_start_counts: got done %0d steps %0d ok=%0d required 1/32/1", done_cnt - d0, step_cnt - s0, ok);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ignore_start_not_queued: got busy %b required 0", busy);
    else n_pass++;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (mism != 0 || got_q.size() != exp_q.size())
      $display("FAIL ignore_start_stream: got %0d bytes %0d mismatches required 128/0", got_q.size(), mism);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    int s0, e, mism;
    bit ok;
    exp_q.delete(); got_q.delete();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (widx == 5'd10 && txv) break;
      cycle();
    end
    rst = 1'b1;
    cycle();
    n_checks++;
    if ({busy, txv, done, step, widx} !== '0)
      $display("FAIL mid_reset_outputs: got %b required 0", {busy, txv, done, step, widx});
    else n_pass++;
    rst = 1'b0;
    cycle();
    exp_q.delete(); got_q.delete();
    s0 = step_cnt;
    push_dump();
    pulse_start();
    cycle();
    n_checks++;
    if ({txv, txd} !== {1'b1, 8'h00}) $display("FAIL after_reset_first: got %b/%h required 1/00", txv, txd);
    else n_pass++;
    wait_done(1'b0, e, ok);
    repeat (3) cycle();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (!ok || mism != 0 || got_q.size() != exp_q.size() || step_cnt - s0 != 32)
      $display("FAIL after_reset_stream: got %0d bytes %0d mismatches %0d steps required 128/0/32",
               got_q.size(), mism, step_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0, e, mism;
    bit ok1, ok2;
    exp_q.delete(); got_q.delete();
    s0 = step_cnt;
    push_dump();
    push_dump();
    pulse_start();
    wait_done(1'b0, e, ok1);
    cycle();
    pulse_start();
    cycle();
    n_checks++;
    if ({txv, txd} !== {1'b1, 8'h00}) $display("FAIL b2b_second_first: got %b/%h required 1/00", txv, txd);
    else n_pass++;
    wait_done(1'b0, e, ok2);
    repeat (3) cycle();
    n_checks++;
    if (!ok1 || !ok2 || step_cnt - s0 != 64)
      $display("FAIL b2b_steps: got %0d ok=%0d%0d required 64", step_cnt - s0, ok1, ok2);
    else n_pass++;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (mism != 0 || got_q.size() != exp_q.size())
      $display("FAIL b2b_stream: got %0d bytes %0d mismatches required 256/0", got_q.size(), mism);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    int s0, o0, e, mism;
    bit ok;
    exp_q.delete(); got_q.delete();
    s0 = step_cnt; o0 = overlap_cnt;
    push_dump();
    pulse_start();
    wait_done(1'b1, e, ok);
    repeat (3) cycle();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    n_checks++;
    if (!ok || mism != 0 || got_q.size() != exp_q.size())
      $display("FAIL rand_stream: got %0d bytes %0d mismatches ok=%0d required 128/0/1", got_q.size(), mism, ok);
    else n_pass++;
    n_checks++;
    if (overlap_cnt - o0 != 0 || step_cnt - s0 != 32)
      $display("FAIL rand_step_overlap: got overlap %0d steps %0d required 0/32", overlap_cnt - o0, step_cnt - s0);
    else n_pass++;
  endtask

  initial begin
    // Word k carries k in its low byte and C0+k in byte 1; words 2 and 31
    // hold distinctive small values.
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA0B0C000 + 32'(k) * 32'h0101;
    mem[2]  = 32'h00000063;
    mem[31] = 32'h00000064;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_ignore_start();
    test_reset_mid_dump();
    test_back_to_back();
    test_random_ready();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
